m_axis_mem: RTL and testbench

- AXI4-Stream master that reads a burst of words from a synchronous single-port memory and streams them out. It is the transmit-side counterpart of the receive-side stream-to-memory stage.
- A controller pulses tx_start with a base address and length. The block prefetches through a 2-entry output buffer, sustains 1 beat/cycle, and pulses tx_done after the tlast handshake.

---
 rtl/m_axis_mem.sv | 170 +++++++++++++++++
 tb/tb_m_axis_mem.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_axis_mem.sv
// m_axis_mem: AXI4-Stream master that streams a burst of words read from a
// synchronous single-port memory (1-cycle read latency).
// Prefetches through a 2-entry output buffer so that bursts run at one beat
// per cycle while tready stays high.
// Optional build macro M_AXIS_MEM_LAST_STRB_EN adds tx_last_strb, which is
// used as the tstrb of the tlast beat; without it every beat has all-ones tstrb.
//
// Handshake: a beat transfers on any rising edge with tvalid & tready both high.
// tvalid and the beat payload come only from buffer registers, so they never
// depend combinationally on tready, and they hold steady while stalled.
module m_axis_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                    m_axis_aclk,
    input  logic                    m_axis_areset,
    input  logic                    tx_start,
    input  logic [ADDR_WIDTH-1:0]   tx_base,
    input  logic [ADDR_WIDTH-1:0]   tx_len,
`ifdef M_AXIS_MEM_LAST_STRB_EN
    input  logic [DATA_WIDTH/8-1:0] tx_last_strb,
`endif
    output logic                    tx_busy,
    output logic                    tx_done,
    output logic                    mem_read_en,
    output logic [ADDR_WIDTH-1:0]   mem_read_address,
    input  logic [DATA_WIDTH-1:0]   mem_read_data,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic                    m_axis_tlast
);

    localparam int SW = DATA_WIDTH / 8;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] len_q;
    logic [ADDR_WIDTH-1:0] rd_idx_q;
    logic                  inflight_q;
    logic                  inflight_last_q;
    logic                  done_q;
    logic [1:0]            count_q;
    logic [DATA_WIDTH-1:0] data0_q, data1_q;
    logic                  last0_q, last1_q;
    logic [SW-1:0]         strb0_q, strb1_q;

    logic                  pop;
    logic                  push;
    logic                  rd_en;
    logic                  rd_last;
    logic [2:0]            level;
    logic [1:0]            count_d;
    logic [1:0]            push_slot;
    logic [SW-1:0]         push_strb;

`ifdef M_AXIS_MEM_LAST_STRB_EN
    logic [SW-1:0]         last_strb_q;

    // Latch the final-beat strobe along with the burst descriptor.
    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_areset) begin
            last_strb_q <= '0;
        end else if (state_q == S_IDLE && tx_start) begin
            last_strb_q <= tx_last_strb;
        end
    end

    assign push_strb = inflight_last_q ? last_strb_q : '1;
`else
    assign push_strb = '1;
`endif

    // Occupancy bookkeeping and read-issue decision for the current cycle.
    // A read may issue when buffered + in-flight - leaving entries stays below
    // 2, so the returning word always has a free slot.
    always_comb begin
        pop       = (count_q != 2'd0) && m_axis_tready;
        push      = inflight_q;
        level     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        rd_en     = (state_q == S_READ) && (level < 3'd2);
        rd_last   = (rd_idx_q == len_q);
        count_d   = count_q + {1'b0, push} - {1'b0, pop};
        push_slot = count_q - {1'b0, pop};
    end

    // Burst FSM, read tracking and the 2-entry output buffer (head = entry 0).
    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_areset) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            len_q           <= '0;
            rd_idx_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
            count_q         <= 2'd0;
            data0_q         <= '0;
            data1_q         <= '0;
            last0_q         <= 1'b0;
            last1_q         <= 1'b0;
            strb0_q         <= '0;
            strb1_q         <= '0;
        end else begin
            done_q          <= 1'b0;
            inflight_q      <= rd_en;
            inflight_last_q <= rd_en && rd_last;
            count_q         <= count_d;

            case (state_q)
                S_IDLE: begin
                    if (tx_start) begin
                        addr_q   <= tx_base;
                        len_q    <= tx_len;
                        rd_idx_q <= '0;
                        state_q  <= S_READ;
                    end
                end
                S_READ: begin
                    if (rd_en) begin
                        addr_q   <= addr_q + 1'b1;
                        rd_idx_q <= rd_idx_q + 1'b1;
                        if (rd_last) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop && last0_q) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // Advance the queue on a handshake, then place returning data in
            // the first slot that remains free after that pop.
            if (pop) begin
                data0_q <= data1_q;
                last0_q <= last1_q;
                strb0_q <= strb1_q;
            end
            if (push) begin
                if (push_slot == 2'd0) begin
                    data0_q <= mem_read_data;
                    last0_q <= inflight_last_q;
                    strb0_q <= push_strb;
                end else begin
                    data1_q <= mem_read_data;
                    last1_q <= inflight_last_q;
                    strb1_q <= push_strb;
                end
            end
        end
    end

    assign tx_busy          = (state_q != S_IDLE);
    assign tx_done          = done_q;
    assign mem_read_en      = rd_en;
    assign mem_read_address = addr_q;
    assign m_axis_tvalid    = (count_q != 2'd0);
    assign m_axis_tdata     = data0_q;
    assign m_axis_tstrb     = strb0_q;
    assign m_axis_tlast     = last0_q;

endmodule

// File: tb/tb_m_axis_mem.sv
// Directed testbench for m_axis_mem with a synchronous memory model and a
// beat scoreboard. Build with M_AXIS_MEM_LAST_STRB_EN to cover tx_last_strb.
module tb_m_axis_mem;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int SW = DW / 8;
    localparam int EW = DW + 1 + SW;
`ifdef M_AXIS_MEM_LAST_STRB_EN
    localparam logic [SW-1:0] LSTRB = 4'h3;
`else
    localparam logic [SW-1:0] LSTRB = 4'hF;
`endif

    logic          clk = 1'b0;
    logic          areset;
    logic          tx_start;
    logic [AW-1:0] tx_base;
    logic [AW-1:0] tx_len;
`ifdef M_AXIS_MEM_LAST_STRB_EN
    logic [SW-1:0] tx_last_strb;
`endif
    logic          tx_busy;
    logic          tx_done;
    logic          mem_read_en;
    logic [AW-1:0] mem_read_address;
    logic [DW-1:0] mem_read_data = '0;
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;
    logic [SW-1:0] tstrb;
    logic          tlast;

    logic [DW-1:0] mem [32];

    int errors = 0;
    int checks = 0;

    logic [EW-1:0] exp_q[$];
    int            beat_cyc_q[$];
    int            accept_cyc_q[$];
    int            done_cyc_q[$];
    logic [AW-1:0] rd_addr_q[$];
    int            cyc = 0;
    int            rd_pulses = 0;
    int            beats = 0;
    int            done_cnt = 0;
    int            outstanding = 0;
    int            max_out = 0;
    logic          prev_stall = 1'b0;
    logic [EW:0]   prev_vec = '0;
    logic [EW-1:0] mon_e;

    // Clock generation
    always #5 clk = ~clk;

    m_axis_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .m_axis_aclk      (clk),
        .m_axis_areset    (areset),
        .tx_start         (tx_start),
        .tx_base          (tx_base),
        .tx_len           (tx_len),
`ifdef M_AXIS_MEM_LAST_STRB_EN
        .tx_last_strb     (tx_last_strb),
`endif
        .tx_busy          (tx_busy),
        .tx_done          (tx_done),
        .mem_read_en      (mem_read_en),
        .mem_read_address (mem_read_address),
        .mem_read_data    (mem_read_data),
        .m_axis_tvalid    (tvalid),
        .m_axis_tready    (tready),
        .m_axis_tdata     (tdata),
        .m_axis_tstrb     (tstrb),
        .m_axis_tlast     (tlast)
    );

    // Synchronous memory: data valid one cycle after the read strobe
    always @(posedge clk) begin
        if (mem_read_en) mem_read_data <= mem[mem_read_address];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] d, input logic l, input logic [SW-1:0] s);
        exp_q.push_back({d, l, s});
    endtask

    task automatic start_burst(input logic [AW-1:0] b, input logic [AW-1:0] l);
        @(posedge clk); #1;
        tx_start = 1'b1; tx_base = b; tx_len = l;
        @(posedge clk); #1;
        tx_start = 1'b0;
    endtask

    task automatic wait_done(input int n0, input int budget);
        int i = 0;
        while (done_cnt == n0 && i < budget) begin
            @(posedge clk);
            i++;
        end
        chk("done_seen", done_cnt, n0 + 1);
    endtask

    // Monitor / scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        cyc++;
        if (areset) begin
            outstanding = 0;
            prev_stall  = 1'b0;
        end else begin
            if (tx_start && !tx_busy) accept_cyc_q.push_back(cyc);
            if (mem_read_en) begin
                rd_pulses++;
                rd_addr_q.push_back(mem_read_address);
            end
            if (tx_done) begin
                done_cnt++;
                done_cyc_q.push_back(cyc);
            end
            if (prev_stall) chk("stall_hold", {tvalid, tdata, tlast, tstrb}, prev_vec);
            if (tvalid && tready) begin
                beats++;
                beat_cyc_q.push_back(cyc);
                chk("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("beat", {tdata, tlast, tstrb}, mon_e);
                end
            end
            outstanding += int'(mem_read_en) - int'(tvalid && tready);
            if (outstanding > max_out) max_out = outstanding;
            prev_stall = tvalid && !tready;
            prev_vec   = {tvalid, tdata, tlast, tstrb};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, nb, na, r0, ra, b0, i, n;
        logic [AW-1:0] wrap_addr [4];
        logic [5:0]    bp_pat;

        wrap_addr = '{5'd30, 5'd31, 5'd0, 5'd1};
        bp_pat    = 6'b101001;

        // Reset
        areset = 1'b1; tx_start = 1'b0; tx_base = '0; tx_len = '0; tready = 1'b0;
`ifdef M_AXIS_MEM_LAST_STRB_EN
        tx_last_strb = 4'hF;
`endif
        for (int k = 0; k < 32; k++) mem[k] = 32'hC000_0000 + k;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_rd_en", mem_read_en, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_tstrb", tstrb, 0);
        @(posedge clk); #1;
        areset = 1'b0;

        // Single-beat burst with exact cycle timing
        mem[3] = 32'hA5A5_0001;
        tready = 1'b1;
        push_exp(32'hA5A5_0001, 1'b1, 4'hF);
        r0 = rd_pulses;
        start_burst(5'd3, 5'd0);
        @(negedge clk);   // N+1
        chk("t1_rd_en", mem_read_en, 1);
        chk("t1_addr", mem_read_address, 3);
        chk("t1_busy", tx_busy, 1);
        chk("t1_tvalid_n1", tvalid, 0);
        @(negedge clk);   // N+2
        chk("t1_tvalid_n2", tvalid, 0);
        chk("t1_rd_en_n2", mem_read_en, 0);
        @(negedge clk);   // N+3
        chk("t1_tvalid_n3", tvalid, 1);
        chk("t1_tdata", tdata, 32'hA5A5_0001);
        chk("t1_tlast", tlast, 1);
        chk("t1_tstrb", tstrb, 4'hF);
        @(negedge clk);   // N+4
        chk("t1_done", tx_done, 1);
        chk("t1_busy_done", tx_busy, 0);
        chk("t1_tvalid_n4", tvalid, 0);
        @(negedge clk);
        chk("t1_done_pulse", tx_done, 0);
        chk("t1_reads", rd_pulses - r0, 1);
        chk("t1_sb_empty", exp_q.size(), 0);

        // Full-rate burst
        for (int k = 0; k < 8; k++) begin
            mem[k] = 32'h100 + k;
            push_exp(32'h100 + k, k == 7, 4'hF);
        end
        n0 = done_cnt; nb = beat_cyc_q.size(); na = accept_cyc_q.size(); r0 = rd_pulses;
        start_burst(5'd0, 5'd7);
        wait_done(n0, 60);
        chk("t2_sb_empty", exp_q.size(), 0);
        chk("t2_beats", beat_cyc_q.size() - nb, 8);
        chk("t2_reads", rd_pulses - r0, 8);
        if (beat_cyc_q.size() >= nb + 8) begin
            chk("t2_no_gaps", beat_cyc_q[nb + 7] - beat_cyc_q[nb], 7);
            chk("t2_first_latency", beat_cyc_q[nb] - accept_cyc_q[na], 3);
            chk("t2_done_latency", done_cyc_q[n0] - beat_cyc_q[nb + 7], 1);
        end

        // Address wrap-around
        push_exp(32'hC000_001E, 1'b0, 4'hF);
        push_exp(32'hC000_001F, 1'b0, 4'hF);
        push_exp(32'h100, 1'b0, 4'hF);
        push_exp(32'h101, 1'b1, 4'hF);
        n0 = done_cnt; ra = rd_addr_q.size();
        start_burst(5'd30, 5'd3);
        wait_done(n0, 40);
        chk("t3_sb_empty", exp_q.size(), 0);
        chk("t3_nreads", rd_addr_q.size() - ra, 4);
        for (int k = 0; k < 4; k++) chk("t3_addr", rd_addr_q[ra + k], wrap_addr[k]);

        // Backpressure with tready pattern 1,0,0,1,0,1
        for (int k = 8; k < 14; k++) push_exp(32'hC000_0000 + k, k == 13, 4'hF);
        n0 = done_cnt; r0 = rd_pulses; max_out = 0; outstanding = 0;
        start_burst(5'd8, 5'd5);
        i = 0;
        while (done_cnt == n0 && i < 200) begin
            @(posedge clk); #1;
            tready = bp_pat[i % 6];
            i++;
        end
        tready = 1'b1;
        chk("t4_done", done_cnt, n0 + 1);
        chk("t4_sb_empty", exp_q.size(), 0);
        chk("t4_reads", rd_pulses - r0, 6);
        chk("t4_max_outstanding", max_out <= 2, 1);

        // Reset during beat 3 of an 8-beat burst
        for (int k = 0; k < 8; k++) push_exp(32'h100 + k, k == 7, 4'hF);
        n0 = done_cnt; b0 = beats;
        start_burst(5'd0, 5'd7);
        i = 0;
        while (beats < b0 + 2 && i < 50) begin
            @(posedge clk);
            i++;
        end
        chk("t5_two_beats", beats - b0, 2);
        #1 areset = 1'b1;
        @(posedge clk); #1;
        areset = 1'b0;
        @(negedge clk);
        chk("t5_tvalid", tvalid, 0);
        chk("t5_busy", tx_busy, 0);
        chk("t5_done", tx_done, 0);
        chk("t5_rd_en", mem_read_en, 0);
        exp_q.delete();
        repeat (10) @(posedge clk);
        chk("t5_no_done", done_cnt, n0);
        push_exp(32'h100, 1'b0, 4'hF);
        push_exp(32'h101, 1'b1, 4'hF);
        start_burst(5'd0, 5'd1);
        wait_done(n0, 30);
        chk("t5_sb_empty", exp_q.size(), 0);

        // Back-to-back bursts with tx_start held high
`ifdef M_AXIS_MEM_LAST_STRB_EN
        tx_last_strb = 4'h3;
`endif
        for (int k = 0; k < 3; k++) begin
            push_exp(32'hC000_0010, 1'b0, 4'hF);
            push_exp(32'hC000_0011, 1'b1, LSTRB);
        end
        na = accept_cyc_q.size(); r0 = rd_pulses; b0 = beats;
        @(posedge clk); #1;
        tx_start = 1'b1; tx_base = 5'd16; tx_len = 5'd1;
        n = 0; i = 0;
        while (i < 100) begin
            @(negedge clk);
            i++;
            if (tx_done) begin
                n++;
                if (n == 3) break;
            end
        end
        tx_start = 1'b0;
        chk("t6_three_done", n, 3);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("t6_idle", tx_busy, 0);
        chk("t6_reads", rd_pulses - r0, 6);
        chk("t6_beats", beats - b0, 6);
        chk("t6_sb_empty", exp_q.size(), 0);
        if (accept_cyc_q.size() >= na + 2)
            chk("t6_restart_gap", accept_cyc_q[na + 1] - accept_cyc_q[na], 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
